// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// General-purpose register file for the five-stage pipeline, combined with a
// per-register pending-write scoreboard used by ID for RAW hazard detection.
//
//   - Two combinational read ports (S, T) and one write port (WB).
//   - Register 0 always reads as zero and can never be written or marked busy.
//   - BYPASS=1 forwards a same-cycle WB write to the read ports and lets that
//     write satisfy a pending hazard in the same cycle.
//   - A registered display port shows a register with one cycle of latency.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   rs, rt              read indices;  douts, doutt read data (combinational)
//   we, rd, din         WB write port
//   issue, issue_rd     ID marks issue_rd as having an outstanding producer
//   hazard_s, hazard_t  rs / rt has a pending write not satisfied this cycle
//   pending_cnt         registered number of busy registers
//   rdisp, ddisp        display index and registered display data
//
// Handshake: there is no valid/ready flow control on this block. A write is
// accepted on every posedge with we=1 and rd!=0; an issue is accepted on
// every posedge with issue=1 and issue_rd!=0. The consumer is responsible for
// stalling while hazard_s / hazard_t is high.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] douts,
    output logic [DATA_W-1:0] doutt,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] din,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              hazard_s,
    output logic              hazard_t,
    output logic [ADDR_W:0]   pending_cnt,
    input  logic [ADDR_W-1:0] rdisp,
    output logic [DATA_W-1:0] ddisp
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   busy_count;
    logic              fwd_s;
    logic              fwd_t;

    // A WB write matching a read index is forwarded only when bypass is built in.
    assign fwd_s = BYPASS && we && (rd == rs);
    assign fwd_t = BYPASS && we && (rd == rt);

    // Read ports: index 0 is forced to zero, so regs[0] is never relied upon.
    always_comb begin
        douts = '0;
        if (rs != '0) begin
            douts = fwd_s ? din : regs[rs];
        end
    end

    always_comb begin
        doutt = '0;
        if (rt != '0) begin
            doutt = fwd_t ? din : regs[rt];
        end
    end

    // A forwarded write satisfies the pending producer in the same cycle.
    assign hazard_s = (rs != '0) && busy[rs] && !fwd_s;
    assign hazard_t = (rt != '0) && busy[rt] && !fwd_t;

    // Scoreboard next state. The issue is applied after the write-clear so a
    // same-cycle issue and write to one index leaves the newer producer busy.
    always_comb begin
        busy_next = busy;
        if (we && (rd != '0)) begin
            busy_next[rd] = 1'b0;
        end
        if (issue && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Popcount of the post-update busy vector, registered as pending_cnt.
    always_comb begin
        busy_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_count = busy_count + (ADDR_W + 1)'(busy_next[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
            busy        <= '0;
            pending_cnt <= '0;
            ddisp       <= '0;
        end else begin
            if (we && (rd != '0)) begin
                regs[rd] <= din;
            end
            // Display samples the array before this cycle's write lands.
            ddisp       <= (rdisp == '0) ? '0 : regs[rdisp];
            busy        <= busy_next;
            pending_cnt <= busy_count;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Drives two instances of regfile_scoreboard (BYPASS=1 and BYPASS=0) from the
// same inputs. A hand-written vector table covers the directed corner cases;
// a randomized phase is checked against a behavioural model of the register
// file and scoreboard (plain arrays). Registered display data is tracked
// through an expected queue.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int W      = DATA_W;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset;
    logic [ADDR_W-1:0] rs, rt, rd, issue_rd, rdisp;
    logic              we, issue;
    logic [DATA_W-1:0] din;

    logic [DATA_W-1:0] douts1, doutt1, ddisp1, douts0, doutt0, ddisp0;
    logic              hs1, ht1, hs0, ht0;
    logic [ADDR_W:0]   cnt1, cnt0;

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_byp (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .douts(douts1), .doutt(doutt1),
        .we(we), .rd(rd), .din(din), .issue(issue), .issue_rd(issue_rd),
        .hazard_s(hs1), .hazard_t(ht1), .pending_cnt(cnt1), .rdisp(rdisp), .ddisp(ddisp1)
    );

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_nob (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .douts(douts0), .doutt(doutt0),
        .we(we), .rd(rd), .din(din), .issue(issue), .issue_rd(issue_rd),
        .hazard_s(hs0), .hazard_t(ht0), .pending_cnt(cnt0), .rdisp(rdisp), .ddisp(ddisp0)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] din;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  rdisp;
        logic [31:0] ds1;   // douts, BYPASS=1 (this cycle)
        logic [31:0] ds0;   // douts, BYPASS=0
        logic [31:0] dt1;
        logic [31:0] dt0;
        logic        hs1;
        logic        hs0;
        logic        ht1;
        logic        ht0;
        logic [5:0]  cnt;   // pending_cnt after the edge
        logic [31:0] dd;    // ddisp after the edge
    } vec_t;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_busy [DEPTH];

    function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp,
                                           input logic w, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (byp && w && (wa == idx)) return wd;
        return m_mem[idx];
    endfunction

    function automatic logic m_haz(input logic [4:0] idx, input bit byp,
                                   input logic w, input logic [4:0] wa);
        if (idx == 0) return 1'b0;
        return m_busy[idx] && !(byp && w && (wa == idx));
    endfunction

    // Fills in the expected outputs of v from the model, then advances the model.
    task automatic model_step(inout vec_t v);
        int pend;
        v.ds1 = m_read(v.rs, 1'b1, v.we, v.rd, v.din);
        v.ds0 = m_read(v.rs, 1'b0, v.we, v.rd, v.din);
        v.dt1 = m_read(v.rt, 1'b1, v.we, v.rd, v.din);
        v.dt0 = m_read(v.rt, 1'b0, v.we, v.rd, v.din);
        v.hs1 = m_haz(v.rs, 1'b1, v.we, v.rd);
        v.hs0 = m_haz(v.rs, 1'b0, v.we, v.rd);
        v.ht1 = m_haz(v.rt, 1'b1, v.we, v.rd);
        v.ht0 = m_haz(v.rt, 1'b0, v.we, v.rd);
        if (v.rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_mem[k]  = 32'h0;
                m_busy[k] = 1'b0;
            end
            v.dd = 32'h0;
        end else begin
            v.dd = (v.rdisp == 0) ? 32'h0 : m_mem[v.rdisp];
            if (v.we && v.rd != 0) begin
                m_mem[v.rd]  = v.din;
                m_busy[v.rd] = 1'b0;
            end
            if (v.iss && v.ird != 0) m_busy[v.ird] = 1'b1;
        end
        pend = 0;
        for (int k = 1; k < DEPTH; k++) pend += m_busy[k] ? 1 : 0;
        v.cnt = 6'(pend);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; drives, checks combinational outputs,
    // lets the rising edge happen, then checks registered outputs.
    task automatic run_vec(input vec_t v, input bit do_comb);
        logic [W-1:0] exp_dd;
        reset    = v.rst;
        rs       = v.rs;
        rt       = v.rt;
        we       = v.we;
        rd       = v.rd;
        din      = v.din;
        issue    = v.iss;
        issue_rd = v.ird;
        rdisp    = v.rdisp;
        exp_q.push_back(v.dd);
        #1;
        if (do_comb) begin
            chk("douts_byp", douts1, v.ds1);
            chk("douts_nob", douts0, v.ds0);
            chk("doutt_byp", doutt1, v.dt1);
            chk("doutt_nob", doutt0, v.dt0);
            chk("hazard_s_byp", hs1, v.hs1);
            chk("hazard_s_nob", hs0, v.hs0);
            chk("hazard_t_byp", ht1, v.ht1);
            chk("hazard_t_nob", ht0, v.ht0);
        end
        @(posedge clock);
        @(negedge clock);
        exp_dd = exp_q.pop_front();
        chk("pending_cnt_byp", cnt1, v.cnt);
        chk("pending_cnt_nob", cnt0, v.cnt);
        chk("ddisp_byp", ddisp1, exp_dd);
        chk("ddisp_nob", ddisp0, exp_dd);
    endtask

    // ---------------- test ----------------
    vec_t tbl [20];
    vec_t v;
    vec_t m;
    vec_t init_v;

    initial begin
        reset = 1'b1; rs = '0; rt = '0; we = 1'b0; rd = '0; din = '0;
        issue = 1'b0; issue_rd = '0; rdisp = '0;

        //          rst rs  rt  we rd  din           iss ird rdisp  ds1           ds0           dt1           dt0           hs1 hs0 ht1 ht0 cnt dd
        tbl[0]  = '{1, 3,  31, 0, 0,  32'h0,         0, 0, 0,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[1]  = '{0, 5,  5,  1, 5,  32'hDEADBEEF,  0, 0, 5,     32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[2]  = '{0, 5,  0,  0, 0,  32'h0,         0, 0, 5,     32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'hDEADBEEF};
        tbl[3]  = '{0, 0,  0,  1, 0,  32'hFFFFFFFF,  0, 0, 0,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[4]  = '{0, 0,  0,  0, 0,  32'h0,         1, 0, 0,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[5]  = '{0, 7,  7,  0, 0,  32'h0,         1, 7, 0,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0};
        tbl[6]  = '{0, 7,  7,  0, 0,  32'h0,         0, 0, 0,     32'h0,        32'h0,        32'h0,        32'h0,        1, 1, 1, 1, 1, 32'h0};
        tbl[7]  = '{0, 7,  7,  1, 7,  32'hA5A5A5A5,  0, 0, 7,     32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 32'h0,        0, 1, 0, 1, 0, 32'h0};
        tbl[8]  = '{0, 7,  0,  0, 0,  32'h0,         0, 0, 7,     32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'hA5A5A5A5};
        tbl[9]  = '{0, 9,  9,  1, 9,  32'h12,        1, 9, 9,     32'h12,       32'h0,        32'h12,       32'h0,        0, 0, 0, 0, 1, 32'h0};
        tbl[10] = '{0, 9,  9,  0, 0,  32'h0,         0, 0, 9,     32'h12,       32'h12,       32'h12,       32'h12,       1, 1, 1, 1, 1, 32'h12};
        tbl[11] = '{0, 0,  0,  1, 9,  32'h34,        0, 0, 0,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[12] = '{0, 3,  0,  0, 0,  32'h0,         1, 3, 0,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 1, 32'h0};
        tbl[13] = '{0, 3,  0,  0, 0,  32'h0,         1, 4, 0,     32'h0,        32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 2, 32'h0};
        tbl[14] = '{0, 4,  0,  0, 0,  32'h0,         1, 6, 0,     32'h0,        32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 3, 32'h0};
        tbl[15] = '{1, 3,  6,  1, 3,  32'h55,        0, 0, 3,     32'h55,       32'h0,        32'h0,        32'h0,        0, 1, 1, 1, 0, 32'h0};
        tbl[16] = '{0, 3,  5,  0, 0,  32'h0,         0, 0, 3,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[17] = '{0, 7,  9,  0, 0,  32'h0,         0, 0, 5,     32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[18] = '{0, 3,  0,  1, 3,  32'h55,        0, 0, 3,     32'h55,       32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0};
        tbl[19] = '{0, 3,  0,  0, 0,  32'h0,         0, 0, 3,     32'h55,       32'h55,       32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h55};

        @(negedge clock);

        // Initial reset: state is undefined before it, so only registered
        // outputs are compared.
        init_v = tbl[0];
        m = init_v;
        model_step(m);
        run_vec(init_v, 1'b0);

        // Directed table; the model tracks along so the random phase starts in sync.
        for (int i = 0; i < 20; i++) begin
            m = tbl[i];
            model_step(m);
            run_vec(tbl[i], 1'b1);
        end

        // Randomized phase, indices biased low so reads, writes, issues collide.
        for (int i = 0; i < 600; i++) begin
            v.rst   = ($urandom_range(0, 49) == 0);
            v.rs    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.rt    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.we    = ($urandom_range(0, 1) == 1);
            v.rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.din   = $urandom;
            v.iss   = ($urandom_range(0, 4) < 2);
            v.ird   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.rdisp = 5'($urandom_range(0, 7));
            model_step(v);
            run_vec(v, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the pipeline's general-purpose register file. It provides a 2-read/1-write register array with register 0 hardwired to zero. Same-cycle write-to-read bypass is optional by parameter. A per-register pending-write scoreboard lets the ID stage detect RAW hazards, and a registered debug display port drives the board display. The block sits between ID (reads, issue) and WB (write) in the five-stage pipeline.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W, entry 0 hardwired to zero
BYPASS, 1, 1 = a WB write to the same index is forwarded to douts/doutt in the same cycle; 0 = reads return the array contents only

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high
rs  in  ADDR_W  read port S index
rt  in  ADDR_W  read port T index
douts  out  DATA_W  read data S (combinational)
doutt  out  DATA_W  read data T (combinational)
we  in  1  write enable (WB)
rd  in  ADDR_W  write index
din  in  DATA_W  write data
issue  in  1  ID issues an instruction that will write issue_rd
issue_rd  in  ADDR_W  destination of the issued instruction
hazard_s  out  1  rs has a pending write not satisfied this cycle
hazard_t  out  1  rt has a pending write not satisfied this cycle
pending_cnt  out  ADDR_W+1  number of set busy bits
rdisp  in  ADDR_W  display register index
ddisp  out  DATA_W  registered display data

Behaviour:
- Reset (synchronous, posedge clock with reset=1): all entries 1..2**ADDR_W-1 are set to 0, all busy bits are cleared, pending_cnt is set to 0, and ddisp is set to 0. Reset overrides we and issue in the same cycle. The outputs douts, doutt, hazard_s and hazard_t reflect the cleared state in the following cycle.
- Write: at posedge, if we=1 and rd!=0, then array[rd] <= din. Writes to rd=0 are ignored.
- Read: douts = 0 if rs=0. Otherwise, if BYPASS=1 and we=1 and rd=rs, douts = din. Otherwise douts = array[rs]. doutt follows the same rules with rt.
- Busy bit update at posedge, per index k!=0:
  - Set if issue=1 and issue_rd=k.
  - Else cleared if we=1 and rd=k.
  - Else held.
  - Issue and write to the same index in the same cycle leaves the bit set, because the new producer is outstanding.
  - Index 0 is never busy.
  - Re-issuing an index that is already busy keeps it busy; there is no counting per register.
- hazard_s = busy[rs] AND NOT (BYPASS=1 AND we=1 AND rd=rs). hazard_s = 0 when rs=0. hazard_t follows the same rules with rt. Both are combinational from current busy state and inputs.
- With BYPASS=0, a pending register being written this cycle still raises its hazard. The consumer must stall one more cycle.
- pending_cnt is a registered popcount of the busy vector after the update. It is 0 after reset and saturates naturally at 2**ADDR_W-1.
- ddisp: at posedge, ddisp <= (rdisp=0) ? 0 : array[rdisp], read before this cycle's write. ddisp therefore has 1-cycle latency and shows the pre-write value on a simultaneous write to rdisp.
- The write and the issue/scoreboard paths are independent. A write to a non-busy register is legal and leaves its busy bit at 0.
- Reset mid-operation discards all pending writes (scoreboard cleared). The pipeline flushes together with the register file.

Test Plan:
- Reset, then read all indices with BYPASS=1 -> douts=doutt=0, hazard_s=hazard_t=0, pending_cnt=0, ddisp=0 after one clock.
- Write we=1 rd=5 din=0xDEADBEEF with rs=5 in the same cycle -> douts=0xDEADBEEF in that cycle (BYPASS=1). With BYPASS=0, douts=0 in that cycle and 0xDEADBEEF in the next.
- Write rd=0 din=0xFFFFFFFF, then rs=0 -> douts=0; issue issue_rd=0 -> pending_cnt stays 0, hazard_s=0.
- issue issue_rd=7; next cycle rs=7 -> hazard_s=1, pending_cnt=1. Then we=1 rd=7 with rs=7 -> hazard_s=0 in the same cycle (BYPASS=1), busy[7] cleared next cycle, pending_cnt=0.
- Same cycle issue issue_rd=9 and we=1 rd=9 din=0x12 -> array[9]=0x12, busy[9] stays 1, hazard_t=1 with rt=9 next cycle.
- issue indices 3, 4, 6 over three cycles, then assert reset together with we=1 rd=3 din=0x55 -> next cycle pending_cnt=0, array[3]=0, ddisp=0.
